ransac_point_rx: RTL

//  Receiving end of the 32-bit point stream feeding the RANSAC core. Accepts a framed word

---
 rtl/ransac_pkg.sv | 34 +++
 rtl/ransac_point_ram.sv | 26 ++
 rtl/ransac_point_rx.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/ransac_pkg.sv
// ransac_pkg: shared types and constants for the RANSAC point receiver.
//  - SYNC_BYTE_DEF : default header sync byte
//  - err_e         : error codes reported on err_code
//  - state_e       : receiver FSM states
//  - field slicing constants for header and point words
package ransac_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_SYNC  = 2'd1,
    ERR_COUNT = 2'd2,
    ERR_CSUM  = 2'd3
  } err_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    DRAIN = 3'd3,
    READY = 3'd4
  } state_e;

  // header word: {sync[31:24], ignored[23:16], n[15:0]}
  localparam int HDR_SYNC_LSB = 24;
  localparam int HDR_N_LSB    = 0;
  localparam int HDR_N_W      = 16;

  // point word: {x[31:16], y[15:0]}
  localparam int PT_X_LSB = 16;
  localparam int PT_Y_LSB = 0;

endpackage

// File: rtl/ransac_point_ram.sv
// ransac_point_ram: DEPTH x W simple dual-port RAM, synchronous write and
// synchronous read (1-cycle latency).
//  CLOCK_50 : clock
//  we/waddr/wdata : write port
//  raddr/rdata    : read port, rdata valid after the edge that samples raddr
module ransac_point_ram #(
  parameter int DEPTH = 64,
  parameter int W     = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          CLOCK_50,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge CLOCK_50) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/ransac_point_rx.sv
// ransac_point_rx: receives a framed 32-bit word stream (header + N points
// [+ XOR checksum]) and holds the points for the RANSAC engine to read by index.
//  CLOCK_50, reset     : clock, async active-high reset
//  in_valid/in_data/in_ready : input word stream
//  frame_valid, n_pts  : stored frame available and its size
//  rd_addr -> rd_x/rd_y: point read, 1-cycle latency, zero when out of range
//  frame_release       : engine done with frame, frees the buffer
//  err_pulse/err_code  : framing error pulse and sticky code
// Optional: define RANSAC_RX_CHECKSUM_EN to expect a trailing XOR checksum word.
module ransac_point_rx
  import ransac_pkg::*;
#(
  parameter int         COORD_W   = 16,
  parameter int         MAX_PTS   = 64,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic                         CLOCK_50,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [31:0]                  in_data,
  output logic                         in_ready,
  output logic                         frame_valid,
  output logic [$clog2(MAX_PTS+1)-1:0] n_pts,
  input  logic [$clog2(MAX_PTS)-1:0]   rd_addr,
  output logic [COORD_W-1:0]           rd_x,
  output logic [COORD_W-1:0]           rd_y,
  input  logic                         frame_release,
  output logic                         err_pulse,
  output logic [1:0]                   err_code
);

  localparam int NW = $clog2(MAX_PTS+1);
  localparam int AW = $clog2(MAX_PTS);
  localparam logic [15:0] MAX_N = 16'(MAX_PTS);

  state_e      state_q, state_d;
  logic [15:0] n_q, wr_ptr, drain_cnt, drain_last, hdr_n;
  logic [7:0]  hdr_sync;
  err_e        err_q, err_d;
  logic        err_set, ld_hdr, wr_en, acc, rd_zero_q;
  logic [31:0] rd_q;
`ifdef RANSAC_RX_CHECKSUM_EN
  logic [31:0] csum_q;
`endif

  assign acc      = in_valid & in_ready;
  assign hdr_sync = in_data[HDR_SYNC_LSB +: 8];
  assign hdr_n    = in_data[HDR_N_LSB +: HDR_N_W];

  // oversize frames also swallow the checksum word when it is present
`ifdef RANSAC_RX_CHECKSUM_EN
  assign drain_last = n_q;
`else
  assign drain_last = 16'(n_q - 16'd1);
`endif

  always_comb begin
    state_d = state_q;
    err_set = 1'b0;
    err_d   = err_q;
    ld_hdr  = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: if (acc) begin
        if (hdr_sync != SYNC_BYTE) begin
          err_set = 1'b1;
          err_d   = ERR_SYNC;
        end else if (hdr_n == 16'd0) begin
          err_set = 1'b1;
          err_d   = ERR_COUNT;
        end else if (hdr_n > MAX_N) begin
          err_set = 1'b1;
          err_d   = ERR_COUNT;
          ld_hdr  = 1'b1;
          state_d = DRAIN;
        end else begin
          ld_hdr  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: if (acc) begin
        wr_en = 1'b1;
        if (wr_ptr == 16'(n_q - 16'd1)) begin
`ifdef RANSAC_RX_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = READY;
`endif
        end
      end
`ifdef RANSAC_RX_CHECKSUM_EN
      CHECK: if (acc) begin
        if (in_data == csum_q) begin
          state_d = READY;
        end else begin
          err_set = 1'b1;
          err_d   = ERR_CSUM;
          state_d = IDLE;
        end
      end
`endif
      DRAIN: if (acc && drain_cnt == drain_last) state_d = IDLE;
      READY: if (frame_release) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      n_q       <= '0;
      wr_ptr    <= '0;
      drain_cnt <= '0;
      err_pulse <= 1'b0;
      err_q     <= ERR_NONE;
      rd_zero_q <= 1'b1;
`ifdef RANSAC_RX_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      err_pulse <= err_set;
      if (err_set) err_q <= err_d;
      if (ld_hdr) begin
        n_q       <= hdr_n;
        wr_ptr    <= '0;
        drain_cnt <= '0;
`ifdef RANSAC_RX_CHECKSUM_EN
        csum_q    <= '0;
`endif
      end else begin
        if (wr_en) begin
          wr_ptr <= wr_ptr + 16'd1;
`ifdef RANSAC_RX_CHECKSUM_EN
          csum_q <= csum_q ^ in_data;
`endif
        end
        if (state_q == DRAIN && acc) drain_cnt <= drain_cnt + 16'd1;
      end
      // range check sampled with the address so it lines up with RAM data
      rd_zero_q <= (state_q != READY) || (16'(rd_addr) >= n_q);
    end
  end

  ransac_point_ram #(.DEPTH(MAX_PTS), .W(32), .AW(AW)) u_ram (
    .CLOCK_50 (CLOCK_50),
    .we       (wr_en),
    .waddr    (wr_ptr[AW-1:0]),
    .wdata    (in_data),
    .raddr    (rd_addr),
    .rdata    (rd_q)
  );

  assign in_ready    = (state_q != READY);
  assign frame_valid = (state_q == READY);
  assign n_pts       = frame_valid ? n_q[NW-1:0] : '0;
  assign err_code    = err_q;
  // current frame_valid also gates, so data vanishes the cycle after release
  assign rd_x = (rd_zero_q || !frame_valid) ? '0 : rd_q[PT_X_LSB +: COORD_W];
  assign rd_y = (rd_zero_q || !frame_valid) ? '0 : rd_q[PT_Y_LSB +: COORD_W];

endmodule
